ntt_layer_scheduler: RTL and testbench
======================================

// Module: ntt_layer_scheduler
// PURPOSE
//  Sequences the Kyber NTT/INTT butterfly datapath over one 256-coefficient polynomial.
//  Issues coefficient address pairs (j, j+len) and the zeta ROM index, layer by layer (7 layers x 128 pairs).
//  Tracks pairs in flight, drains the butterfly pipeline between layers (RAW safety), and signals completion.
//  Sits between the top-level start/is_ntt control and the butterfly unit plus coefficient RAM.
// PARAMETERS
//  WIDTH_ADDR_BUTTERFLY  8  coefficient address width; N = 2**8 = 256, fixed for ML-KEM
//  WIDTH_ADDR_ZETAS      7  zeta ROM index width (128 entries)
//  MAX_OUTSTANDING       8  max issued pairs without write-back; range 1..255
// PORTS
//  clk           in   1  clock, rising edge
//  rst           in   1  synchronous active-high reset
//  start         in   1  begin a transform; sampled only in IDLE
//  is_ntt        in   1  1 = forward NTT, 0 = INTT; latched when start is accepted
//  bf_ready      in   1  butterfly accepts the pair this cycle
//  wb_valid      in   1  one pair written back to RAM this cycle
//  addr_j        out  8  lower coefficient address
//  addr_jl       out  8  upper coefficient address = addr_j + len
//  addr_zetas    out  7  zeta ROM index for the current group
//  valid_addr    out  1  addr_j/addr_jl/addr_zetas valid; issue = valid_addr & bf_ready
//  layer         out  3  current layer 0..6
//  busy          out  1  high from start acceptance until done_compute
//  done_addr     out  1  1-cycle pulse on issue of the final pair of layer 6
//  done_compute  out  1  1-cycle pulse when all 896 pairs are written back
//  check_state   out  2  FSM state code (debug)
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; outstanding = 0. Reset mid-transform aborts; no done pulse.
//  FSM (check_state): IDLE=0, ISSUE=1, DRAIN=2, DONE=3.
//   IDLE->ISSUE on start (latch is_ntt, layer=0, base=0, off=0). start outside IDLE ignored.
//   ISSUE->DRAIN on issue of pair 128 of the layer. DRAIN->ISSUE (layer+1) when outstanding==0 and layer<6.
//   DRAIN->DONE when outstanding==0 and layer==6. DONE->IDLE after 1 cycle; done_compute=1 in DONE.
//  len: NTT = 128>>layer (128..2); INTT = 2<<layer (2..128).
//  addr_j = base+off; addr_jl = addr_j+len (never exceeds 255).
//  On issue: off==len-1 -> off=0, base+=2*len, zeta step; else off+=1. Base 8-bit wrap to 0 ends layer.
//  Zeta: NTT starts k=1 and increments per group (1..127). INTT starts k=127 and decrements per group (127..1).
//  Outstanding counter: +1 on issue, -1 on wb_valid; simultaneous issue+wb = unchanged.
//  valid_addr = (state==ISSUE) && (outstanding < MAX_OUTSTANDING); addresses held stable while stalled.
//  wb_valid with outstanding==0: ignored, counter stays 0.
//  Issue latency: first valid_addr on the cycle after start is sampled.
// CONFIGURATION
//  NTT_SCHED_PERF_EN defined: adds outputs cyc_cnt[15:0] and stall_cnt[15:0].
//   - Both cleared on start acceptance and frozen at done_compute.
//   - cyc_cnt counts busy cycles; stall_cnt counts cycles in ISSUE with valid_addr=0 or bf_ready=0.
//  NTT_SCHED_PERF_EN undefined: these ports and their logic are absent; all other behaviour identical.
// TESTING
//  NTT, bf_ready=1, wb 4 cycles after issue -> first issue (0,128,z=1); 128th (127,255,z=1); layer-1 first (0,64,z=2).
//  NTT layer 6 -> first (0,2,z=64), last (253,255,z=127) with done_addr=1; done_compute 1 cycle, busy falls with it.
//  INTT -> layer 0 first (0,2,z=127), last (253,255,z=64); layer 6 first (0,128,z=1), last (127,255,z=1).
//  MAX_OUTSTANDING=4, wb_valid=0 -> valid_addr drops after 4 issues, holds (4,132,1); one wb pulse -> exactly 1 more issue.
//  bf_ready toggled 1,0,1,0 and start pulsed while busy -> pair sequence unchanged, start ignored, 896 issues total.
//  rst=1 at layer 3 -> next cycle outputs 0, check_state=0; a new start then issues (0,128,z=1) again.

Source files
------------

// File: rtl/ntt_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ntt_layer_scheduler
// Purpose  : Walks the Kyber NTT/INTT butterfly schedule for one 256-coefficient
//            polynomial. It emits (j, j+len, zeta index) per pair, 7 layers of
//            128 pairs each. It limits the number of pairs in flight and drains
//            the butterfly pipeline between layers so that no layer reads a
//            coefficient before the previous layer has written it back.
// Options  : define NTT_SCHED_PERF_EN to add the cyc_cnt / stall_cnt counters.
// Revision : 1.0  initial release
// ============================================================================
module ntt_layer_scheduler #(
    parameter int WIDTH_ADDR_BUTTERFLY = 8,
    parameter int WIDTH_ADDR_ZETAS     = 7,
    parameter int MAX_OUTSTANDING      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            is_ntt,
    input  logic                            bf_ready,
    input  logic                            wb_valid,
    output logic [WIDTH_ADDR_BUTTERFLY-1:0] addr_j,
    output logic [WIDTH_ADDR_BUTTERFLY-1:0] addr_jl,
    output logic [WIDTH_ADDR_ZETAS-1:0]     addr_zetas,
    output logic                            valid_addr,
    output logic [2:0]                      layer,
    output logic                            busy,
    output logic                            done_addr,
    output logic                            done_compute,
    output logic [1:0]                      check_state
`ifdef NTT_SCHED_PERF_EN
    ,
    output logic [15:0]                     cyc_cnt,
    output logic [15:0]                     stall_cnt
`endif
);

    localparam int AW = WIDTH_ADDR_BUTTERFLY;
    localparam int ZW = WIDTH_ADDR_ZETAS;

    localparam logic [AW-1:0] C_HALF       = {1'b1, {(AW-1){1'b0}}};
    localparam logic [AW-1:0] C_TWO        = AW'(2);
    localparam logic [ZW-1:0] C_ZETA_FIRST = ZW'(1);
    localparam logic [ZW-1:0] C_ZETA_LAST  = {ZW{1'b1}};
    localparam logic [2:0]    C_LAST_LAYER = 3'(AW - 2);
    localparam logic [7:0]    C_MAX        = 8'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic          is_ntt_q;
    logic [2:0]    layer_q;
    logic [AW-1:0] base_q;
    logic [AW-1:0] off_q;
    logic [ZW-1:0] zeta_q;
    logic [7:0]    outst_q;
    logic [7:0]    outst_d;

    logic          w_in_issue;
    logic          w_issue;
    logic          w_wb_eff;
    logic [AW-1:0] w_len;
    logic          w_grp_end;
    logic [AW:0]   w_base_next;
    logic [AW-1:0] w_addr_j;

    // Butterfly span: forward transform halves it per layer, inverse doubles it.
    always_comb begin
        w_len = is_ntt_q ? (C_HALF >> layer_q) : (C_TWO << layer_q);
    end

    assign w_in_issue  = (state_q == S_ISSUE);
    assign valid_addr  = w_in_issue && (outst_q < C_MAX);
    assign w_issue     = valid_addr && bf_ready;
    assign w_wb_eff    = wb_valid && (outst_q != 8'd0);
    assign w_grp_end   = (off_q == (w_len - 1'b1));
    // Groups are 2*len aligned, so the carry out of base+2*len marks the layer end.
    assign w_base_next = {1'b0, base_q} + {w_len, 1'b0};
    assign w_addr_j    = base_q + off_q;

    assign addr_j       = w_in_issue ? w_addr_j : '0;
    assign addr_jl      = w_in_issue ? (w_addr_j + w_len) : '0;
    assign addr_zetas   = w_in_issue ? zeta_q : '0;
    assign layer        = layer_q;
    assign busy         = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done_compute = (state_q == S_DONE);
    assign check_state  = state_q;
    assign done_addr    = w_issue && w_grp_end && w_base_next[AW] && (layer_q == C_LAST_LAYER);

    // Pairs-in-flight bookkeeping; a write-back with nothing in flight is dropped.
    always_comb begin
        outst_d = outst_q;
        if (w_issue && !w_wb_eff) begin
            outst_d = outst_q + 8'd1;
        end else if (!w_issue && w_wb_eff) begin
            outst_d = outst_q - 8'd1;
        end
    end

    // Outstanding-pair counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            outst_q <= 8'd0;
        end else begin
            outst_q <= outst_d;
        end
    end

    // Layer sequencer: address walk, zeta stepping and inter-layer drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            is_ntt_q <= 1'b0;
            layer_q  <= 3'd0;
            base_q   <= '0;
            off_q    <= '0;
            zeta_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_ISSUE;
                        is_ntt_q <= is_ntt;
                        layer_q  <= 3'd0;
                        base_q   <= '0;
                        off_q    <= '0;
                        zeta_q   <= is_ntt ? C_ZETA_FIRST : C_ZETA_LAST;
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        if (w_grp_end) begin
                            off_q  <= '0;
                            base_q <= w_base_next[AW-1:0];
                            zeta_q <= is_ntt_q ? (zeta_q + 1'b1) : (zeta_q - 1'b1);
                            if (w_base_next[AW]) begin
                                state_q <= S_DRAIN;
                            end
                        end else begin
                            off_q <= off_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (outst_q == 8'd0) begin
                        if (layer_q == C_LAST_LAYER) begin
                            state_q <= S_DONE;
                        end else begin
                            layer_q <= layer_q + 3'd1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef NTT_SCHED_PERF_EN
    // Busy-cycle and issue-stall counters, cleared on start and frozen once idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt   <= 16'd0;
            stall_cnt <= 16'd0;
        end else if ((state_q == S_IDLE) && start) begin
            cyc_cnt   <= 16'd0;
            stall_cnt <= 16'd0;
        end else if (busy) begin
            cyc_cnt <= cyc_cnt + 16'd1;
            if (w_in_issue && !w_issue) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_layer_scheduler
// Purpose  : Scoreboard bench for ntt_layer_scheduler. A reference pair list is
//            built from the textbook Kyber NTT/INTT loop nest and queued at
//            start; a monitor pops one entry per accepted pair.
// Revision : 1.0  initial release
// ============================================================================
module tb_ntt_layer_scheduler;

    localparam int MAXO    = 4;
    localparam int WB_LAT  = 4;
    localparam int BUDGET  = 8000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_ntt = 1'b0;
    logic        bf_ready = 1'b0;
    logic        wb_manual = 1'b0;
    logic        wb_auto = 1'b0;
    logic        wb_en = 1'b1;
    logic        wb_valid;
    logic [7:0]  addr_j;
    logic [7:0]  addr_jl;
    logic [6:0]  addr_zetas;
    logic        valid_addr;
    logic [2:0]  layer;
    logic        busy;
    logic        done_addr;
    logic        done_compute;
    logic [1:0]  check_state;
`ifdef NTT_SCHED_PERF_EN
    logic [15:0] cyc_cnt;
    logic [15:0] stall_cnt;
`endif

    assign wb_valid = wb_auto | wb_manual;

    ntt_layer_scheduler #(
        .WIDTH_ADDR_BUTTERFLY (8),
        .WIDTH_ADDR_ZETAS     (7),
        .MAX_OUTSTANDING      (MAXO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .is_ntt       (is_ntt),
        .bf_ready     (bf_ready),
        .wb_valid     (wb_valid),
        .addr_j       (addr_j),
        .addr_jl      (addr_jl),
        .addr_zetas   (addr_zetas),
        .valid_addr   (valid_addr),
        .layer        (layer),
        .busy         (busy),
        .done_addr    (done_addr),
        .done_compute (done_compute),
        .check_state  (check_state)
`ifdef NTT_SCHED_PERF_EN
        ,
        .cyc_cnt      (cyc_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Expected pair entry: {j[26:19], j+len[18:11], zeta[10:4], layer[3:1], last[0]}
    logic [26:0] exp_q[$];
    int          n_issued = 0;
    int          run_base = 0;
    int          n_done = 0;
    int          exp_done_total = 0;
    int          out_m = 0;
    logic        issued_flag = 1'b0;
    logic        prev_done = 1'b0;
    logic [WB_LAT-1:0] pipe = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // Reference schedule taken straight from the Kyber loop nest.
    task automatic push_model(input bit ntt);
        int k;
        int len;
        k = ntt ? 0 : 128;
        for (int l = 0; l < 7; l++) begin
            len = ntt ? (128 >> l) : (2 << l);
            for (int s = 0; s < 256; s += 2 * len) begin
                k = ntt ? k + 1 : k - 1;
                for (int j = s; j < s + len; j++) begin
                    exp_q.push_back({8'(j), 8'(j + len), 7'(k), 3'(l),
                                     1'((l == 6) && (j + len == 255))});
                end
            end
        end
    endtask

    // Monitor: scoreboard pops, flow-control and completion checks.
    always @(negedge clk) begin
        logic        issue_m;
        logic [26:0] e;
        issue_m = !rst && valid_addr && bf_ready;
        if (!rst && (check_state == 2'd1)) begin
            check("valid_vs_outstanding", 64'(valid_addr), 64'(out_m < MAXO));
        end
        if (issue_m) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 64'(addr_j), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check("pair", {37'd0, addr_j, addr_jl, addr_zetas, layer, done_addr}, {37'd0, e});
                if ((e[26:19] == 8'd0) && (e[3:1] != 3'd0)) begin
                    check("drained_before_layer", 64'(out_m), 64'd0);
                end
            end
            n_issued++;
        end
        if (prev_done) begin
            check("done_one_cycle", 64'(done_compute), 64'd0);
        end
        if (!rst && done_compute) begin
            check("done_expected", 64'(n_done + 1), 64'(exp_done_total));
            check("busy_low_at_done", 64'(busy), 64'd0);
            check("pairs_at_done", 64'(n_issued - run_base), 64'd896);
            check("queue_empty_at_done", 64'(exp_q.size()), 64'd0);
            n_done++;
        end
        prev_done = !rst && done_compute;
        if (rst) out_m = 0;
        else out_m = out_m + (issue_m ? 1 : 0) - ((wb_valid && out_m > 0) ? 1 : 0);
        issued_flag = issue_m;
    end

    // Write-back model: each accepted pair returns a fixed number of cycles later.
    always @(posedge clk) begin
        #2;
        if (rst) pipe = '0;
        else pipe = {pipe[WB_LAT-2:0], issued_flag};
        wb_auto = wb_en && pipe[WB_LAT-1];
    end

    // mode 0: bf_ready held high; 1: toggling; 2: random plus stray start pulses
    task automatic run_transform(input bit ntt, input int mode);
        int done0;
        int c;
        @(posedge clk); #1;
        push_model(ntt);
        run_base = n_issued;
        exp_done_total++;
        done0 = n_done;
        start = 1'b1;
        is_ntt = ntt;
        bf_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
        check("first_valid", 64'(valid_addr), 64'd1);
        c = 0;
        while ((n_done == done0) && (c < BUDGET)) begin
            @(posedge clk); #1;
            if (mode == 1) begin
                bf_ready = ~bf_ready;
            end else if (mode == 2) begin
                bf_ready = 1'($urandom_range(0, 1));
                start = (check_state != 2'd0) && ($urandom_range(0, 7) == 0);
                is_ntt = 1'($urandom_range(0, 1));
            end
            c++;
        end
        start = 1'b0;
        check("transform_completed", 64'(n_done - done0), 64'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("outputs_after_reset",
              {32'd0, addr_j, addr_jl, addr_zetas, valid_addr, layer, busy, done_addr,
               done_compute, check_state}, 64'd0);
    endtask

    initial begin
        int c;
        int done0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state",
              {32'd0, addr_j, addr_jl, addr_zetas, valid_addr, layer, busy, done_addr,
               done_compute, check_state}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_transform(1'b1, 0);
        run_transform(1'b0, 2);
        run_transform(1'b1, 1);
        run_transform(1'b0, 0);

        // Back-pressure: no write-backs, so only MAXO pairs may go out.
        @(posedge clk); #1;
        wb_en = 1'b0;
        push_model(1'b1);
        run_base = n_issued;
        start = 1'b1;
        is_ntt = 1'b1;
        bf_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_valid_low", 64'(valid_addr), 64'd0);
        check("stall_hold_addr", {41'd0, addr_j, addr_jl, addr_zetas}, {41'd0, 8'd4, 8'd132, 7'd1});
        check("stall_issue_count", 64'(n_issued - run_base), 64'd4);
        @(posedge clk); #1;
        wb_manual = 1'b1;
        @(posedge clk); #1;
        wb_manual = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("one_more_issue", 64'(n_issued - run_base), 64'd5);
        check("stall_hold_addr2", {41'd0, addr_j, addr_jl, addr_zetas}, {41'd0, 8'd5, 8'd133, 7'd1});
        wb_en = 1'b1;
        pulse_reset();

        // Abort in the middle of layer 3, then restart from scratch.
        @(posedge clk); #1;
        push_model(1'b1);
        run_base = n_issued;
        start = 1'b1;
        is_ntt = 1'b1;
        bf_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while ((layer != 3'd3) && (c < BUDGET)) begin
            @(negedge clk);
            c++;
        end
        check("reached_layer3", 64'(layer), 64'd3);
        done0 = n_done;
        pulse_reset();
        repeat (20) @(posedge clk);
        check("no_done_after_abort", 64'(n_done - done0), 64'd0);
        run_transform(1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
